// File: rtl/seg_display_arbiter.sv
// Shares one 4-digit 7-segment display among N_REQ requesters: round-robin ownership,
// minimum hold time and a 9999 clamp. Define DISP_ARB_PRIORITY_EN to make requester 0 urgent.
module seg_display_arbiter #(
    parameter int N_REQ       = 3,
    parameter int DATA_W      = 14,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] value,
    output logic [N_REQ-1:0]        grant,
    output logic [DATA_W-1:0]       displayed_number,
    output logic                    active,
    output logic                    overflow
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int HC_W  = $clog2(HOLD_CYCLES);
    localparam logic [HC_W-1:0]  HOLD_LOAD = HC_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] PTR_RST   = IDX_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE       = N_REQ'(1);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t              state_q;
    logic [N_REQ-1:0]    grant_q;
    logic [DATA_W-1:0]   disp_q;
    logic                active_q;
    logic                ovf_q;
    logic [HC_W-1:0]     hold_q;
    logic [IDX_W-1:0]    rr_ptr_q;

    logic [IDX_W:0]      pick_all;
    logic [IDX_W:0]      pick_oth;
    logic [DATA_W-1:0]   owner_val;
    logic                owner_req;
    logic                urgent;
    logic                lock0;
    logic                take_en;
    logic [IDX_W-1:0]    take_idx;
    logic                go_idle;

    function automatic logic is_over(input logic [DATA_W-1:0] v);
        return 32'(v) > 32'd9999;
    endfunction

    function automatic logic [DATA_W-1:0] sat_9999(input logic [DATA_W-1:0] v);
        if (is_over(v)) return DATA_W'(9999);
        return v;
    endfunction

    // First set bit of mask strictly after ptr, wrapping; MSB of the result flags a hit.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] mask,
                                               input logic [IDX_W-1:0] ptr);
        logic [IDX_W:0] res;
        int idx;
        res = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            for (int j = 0; j < N_REQ; j++) begin
                if (j == idx && mask[j]) res = {1'b1, IDX_W'(j)};
            end
        end
        return res;
    endfunction

`ifdef DISP_ARB_PRIORITY_EN
    assign urgent = req[0] && !grant_q[0];
    assign lock0  = req[0] && grant_q[0];
`else
    assign urgent = 1'b0;
    assign lock0  = 1'b0;
`endif

    always_comb begin
        pick_all  = rr_pick(req, rr_ptr_q);
        pick_oth  = rr_pick(req & ~grant_q, rr_ptr_q);
        owner_req = |(req & grant_q);
        owner_val = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (rr_ptr_q == IDX_W'(i)) owner_val = value[i*DATA_W +: DATA_W];
        end
    end

    // Ownership decision: urgent requester, fresh grant, release, or hold-expiry rotation.
    always_comb begin
        take_en  = 1'b0;
        take_idx = '0;
        go_idle  = 1'b0;
        if (urgent) begin
            take_en  = 1'b1;
            take_idx = '0;
        end else if (state_q == IDLE) begin
            take_en  = pick_all[IDX_W];
            take_idx = pick_all[IDX_W-1:0];
        end else if (!owner_req) begin
            take_en  = pick_all[IDX_W];
            take_idx = pick_all[IDX_W-1:0];
            go_idle  = !pick_all[IDX_W];
        end else if (hold_q == '0 && !lock0) begin
            take_en  = pick_oth[IDX_W];
            take_idx = pick_oth[IDX_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            disp_q   <= '0;
            active_q <= 1'b0;
            ovf_q    <= 1'b0;
            hold_q   <= '0;
            rr_ptr_q <= PTR_RST;
        end else begin
            if (state_q == SHOW) begin
                disp_q <= sat_9999(owner_val);
                ovf_q  <= is_over(owner_val);
            end
            if (take_en) begin
                grant_q  <= ONE << take_idx;
                rr_ptr_q <= take_idx;
                hold_q   <= HOLD_LOAD;
                active_q <= 1'b1;
                state_q  <= SHOW;
            end else if (go_idle) begin
                grant_q  <= '0;
                active_q <= 1'b0;
                disp_q   <= '0;
                ovf_q    <= 1'b0;
                state_q  <= IDLE;
            end else if (state_q == SHOW && hold_q != '0) begin
                hold_q <= hold_q - HC_W'(1);
            end
        end
    end

    assign grant            = grant_q;
    assign displayed_number = disp_q;
    assign active           = active_q;
    assign overflow         = ovf_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: directed steps plus random traffic against an owner/age model.
// Honours DISP_ARB_PRIORITY_EN when the design is built with it.
module tb_seg_display_arbiter;
    localparam int N  = 3;
    localparam int DW = 14;
    localparam int H  = 8;
`ifdef DISP_ARB_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] value = '0;
    logic [N-1:0]    grant;
    logic [DW-1:0]   displayed_number;
    logic            active;
    logic            overflow;

    int vals [N];
    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model: who owns the screen and for how many cycles it has been shown.
    int m_owner;
    int m_age;
    int m_ptr;
    int m_disp;
    bit m_ovf;

    seg_display_arbiter #(.N_REQ(N), .DATA_W(DW), .HOLD_CYCLES(H)) dut (
        .clk              (clk),
        .rst              (rst),
        .req              (req),
        .value            (value),
        .grant            (grant),
        .displayed_number (displayed_number),
        .active           (active),
        .overflow         (overflow)
    );

    always #5 clk = ~clk;

    task automatic set_vals(input int v0, input int v1, input int v2);
        vals[0] = v0; vals[1] = v1; vals[2] = v2;
        value = {14'(v2), 14'(v1), 14'(v0)};
    endtask

    function automatic bit req_bit(input int i);
        return ((int'(req) >> i) & 1) != 0;
    endfunction

    function automatic int pick(input int from, input int excl);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (from + k) % N;
            if (req_bit(idx) && idx != excl) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_age = 0; m_ptr = N - 1; m_disp = 0; m_ovf = 1'b0;
    endtask

    task automatic model_edge();
        int nxt;
        nxt = -1;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_owner >= 0) begin
            m_disp = (vals[m_owner] > 9999) ? 9999 : vals[m_owner];
            m_ovf  = vals[m_owner] > 9999;
        end
        if (PRIO && req_bit(0) && m_owner != 0) begin
            nxt = 0;
        end else if (m_owner < 0) begin
            nxt = pick(m_ptr, -1);
        end else if (!req_bit(m_owner)) begin
            nxt = pick(m_ptr, -1);
            if (nxt < 0) begin
                m_owner = -1; m_disp = 0; m_ovf = 1'b0;
                return;
            end
        end else if (m_age >= H && !(PRIO && m_owner == 0)) begin
            nxt = pick(m_ptr, m_owner);
        end
        if (nxt >= 0) begin
            m_owner = nxt; m_ptr = nxt; m_age = 1;
        end else if (m_owner >= 0) begin
            m_age++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [N-1:0] mg;
        @(posedge clk);
        model_edge();
        #1;
        mg = (m_owner < 0) ? '0 : N'(1 << m_owner);
        check("model_grant",  32'(grant), 32'(mg));
        check("model_active", 32'(active), 32'(m_owner >= 0));
        check("model_disp",   32'(displayed_number), 32'(m_disp));
        check("model_ovf",    32'(overflow), 32'(m_ovf));
    endtask

    initial begin
        model_reset();
        set_vals(0, 0, 0);
        repeat (3) step();
        rst = 1'b0;

        // Idle after reset.
        for (int c = 0; c < 20; c++) begin
            step();
            check("idle_grant", 32'(grant), 32'd0);
            check("idle_active", 32'(active), 32'd0);
            check("idle_disp", 32'(displayed_number), 32'd0);
        end

        // All three requesting: rotation every H cycles.
        set_vals(11, 22, 33);
        req = 3'b111;
        for (int c = 0; c < 32; c++) begin
            int owner;
            step();
            owner = PRIO ? 0 : (c / H) % N;
            check("rr_grant", 32'(grant), 32'(1 << owner));
            if (c % H == 3) check("rr_disp", 32'(displayed_number), 32'(vals[owner]));
        end

        // Clamp and overflow, then live tracking.
        req = 3'b000;
        repeat (2) step();
        set_vals(0, 12345, 0);
        req = 3'b010;
        step();
        check("clamp_grant", 32'(grant), 32'b010);
        step();
        check("clamp_disp", 32'(displayed_number), 32'd9999);
        check("clamp_ovf", 32'(overflow), 32'd1);
        set_vals(0, 42, 0);
        step();
        check("track_disp", 32'(displayed_number), 32'd42);
        check("track_ovf", 32'(overflow), 32'd0);

        // Owner drops mid-hold with another request pending.
        req = 3'b000;
        repeat (2) step();
        req = 3'b010;
        step();
        repeat (2) step();
        req = 3'b100;
        step();
        check("drop_grant", 32'(grant), 32'b100);

        // Lone owner past expiry, then a competitor gets in immediately.
        for (int c = 0; c < 12; c++) step();
        check("held_grant", 32'(grant), 32'b100);
        req = 3'b101;
        step();
        check("expired_rotate", 32'(grant), 32'b001);

        // Asynchronous reset while showing.
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_grant", 32'(grant), 32'd0);
        check("arst_active", 32'(active), 32'd0);
        check("arst_disp", 32'(displayed_number), 32'd0);
        check("arst_ovf", 32'(overflow), 32'd0);
        req = 3'b000;
        repeat (2) step();
        rst = 1'b0;

        // Requester 0 rises while requester 2 is mid-hold.
        req = 3'b100;
        step();
        step();
        req = 3'b101;
        step();
        check("urgent_grant", 32'(grant), PRIO ? 32'b001 : 32'b100);
        for (int c = 0; c < 5; c++) begin
            step();
            check("urgent_stay", 32'(grant), PRIO ? 32'b001 : 32'b100);
        end
        req = 3'b000;
        repeat (3) step();

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) begin
                int v [N];
                for (int i = 0; i < N; i++)
                    v[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9995, 10003))
                                                       : int'($urandom_range(0, 16383));
                set_vals(v[0], v[1], v[2]);
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
